// File: rtl/cache_arb_pkg.sv
// ============================================================================
// Module  : cache_arb_pkg
// Brief   : Shared state encoding and parameter defaults for the cache port
//           arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_arb_pkg;

  localparam int c_ADDR_W         = 32;
  localparam int c_DATA_W         = 32;
  localparam int c_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_arb_rr.sv
// ============================================================================
// Module  : cache_arb_rr
// Brief   : Two-way round-robin pick with last-served pointer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_arb_rr
  import cache_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served,
  output logic       o_pick
);

  // Resets to P1 so that P0 wins the first tie.
  logic r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_update) begin
      r_last <= i_served;
    end
  end

  always_comb begin
    o_pick = 1'b0;
    case (i_req)
      2'b10:   o_pick = 1'b1;
      2'b11:   o_pick = ~r_last;
      default: o_pick = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cache_port_arbiter.sv
// ============================================================================
// Module  : cache_port_arbiter
// Brief   : Two-requester arbiter in front of a single memory port; optional
//           ISSUE watchdog enabled by macro CACHE_ARB_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W         = c_ADDR_W,
  parameter int DATA_W         = c_DATA_W,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid_P0,
  input  logic              reqValid_P1,
  input  logic [ADDR_W-1:0] reqAddress_P0,
  input  logic [ADDR_W-1:0] reqAddress_P1,
  input  logic [DATA_W-1:0] reqDataIn_P0,
  input  logic [DATA_W-1:0] reqDataIn_P1,
  input  logic              reqWen_P0,
  input  logic              reqWen_P1,
  output logic [DATA_W-1:0] respDataOut_P0,
  output logic [DATA_W-1:0] respDataOut_P1,
  output logic              respHit_P0,
  output logic              respHit_P1,
  output logic              reqValid_CPU,
  output logic [ADDR_W-1:0] reqAddress_CPU,
  output logic [DATA_W-1:0] reqDataIn_CPU,
  output logic              reqWen_CPU,
  input  logic [DATA_W-1:0] respDataOut_CPU,
  input  logic              respHit_CPU,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 1023)) begin : g_bad_timeout
    $error("cache_port_arbiter: TIMEOUT_CYCLES must be within 2..1023");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [1:0]        r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [DATA_W-1:0] r_resp_data;

  logic [1:0] w_req;
  logic       w_pick;
  logic       w_hit;
  logic       w_timeout;
  logic       w_done;
  logic       w_owner_valid;
  logic       w_load;
  logic       w_release;

  assign w_req         = {reqValid_P1, reqValid_P0};
  assign w_hit         = (r_state == ST_ISSUE) && respHit_CPU;
  assign w_done        = w_hit || w_timeout;
  assign w_owner_valid = r_grant[1] ? reqValid_P1 : reqValid_P0;

  cache_arb_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_update (w_done),
    .i_served (r_grant[1]),
    .o_pick   (w_pick)
  );

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_ISSUE)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // A response arriving in the expiry cycle takes priority over the watchdog.
  assign w_timeout = (r_state == ST_ISSUE) && !respHit_CPU &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
    end
  end

  assign timeout_err = r_timeout;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt = ST_ISSUE;
          w_load      = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (w_done) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!w_owner_valid) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wen       <= 1'b0;
      r_resp_data <= '0;
    end else begin
      if (w_load) begin
        r_addr  <= w_pick ? reqAddress_P1 : reqAddress_P0;
        r_wdata <= w_pick ? reqDataIn_P1  : reqDataIn_P0;
        r_wen   <= w_pick ? reqWen_P1     : reqWen_P0;
        r_grant <= w_pick ? 2'b10 : 2'b01;
      end
      if (w_hit) begin
        r_resp_data <= respDataOut_CPU;
      end else if (w_timeout) begin
        r_resp_data <= '0;
      end
      if (w_release) begin
        r_grant <= '0;
      end
    end
  end

  assign reqValid_CPU   = (r_state == ST_ISSUE);
  assign reqAddress_CPU = r_addr;
  assign reqDataIn_CPU  = r_wdata;
  assign reqWen_CPU     = r_wen;
  assign grant          = r_grant;

  // Responses are visible only to the owner, and only while in GAP.
  assign respHit_P0     = (r_state == ST_GAP) && r_grant[0];
  assign respHit_P1     = (r_state == ST_GAP) && r_grant[1];
  assign respDataOut_P0 = respHit_P0 ? r_resp_data : '0;
  assign respDataOut_P1 = respHit_P1 ? r_resp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
// ============================================================================
// Module  : tb_cache_port_arbiter
// Brief   : Self-checking bench for cache_port_arbiter (TIMEOUT_CYCLES=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid_P0, reqValid_P1;
  logic [AW-1:0] reqAddress_P0, reqAddress_P1;
  logic [DW-1:0] reqDataIn_P0, reqDataIn_P1;
  logic          reqWen_P0, reqWen_P1;
  logic [DW-1:0] respDataOut_P0, respDataOut_P1;
  logic          respHit_P0, respHit_P1;
  logic          reqValid_CPU;
  logic [AW-1:0] reqAddress_CPU;
  logic [DW-1:0] reqDataIn_CPU;
  logic          reqWen_CPU;
  logic [DW-1:0] respDataOut_CPU;
  logic          respHit_CPU;
  logic [1:0]    grant;
  logic          timeout_err;

  cache_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .reqValid_P0     (reqValid_P0),
    .reqValid_P1     (reqValid_P1),
    .reqAddress_P0   (reqAddress_P0),
    .reqAddress_P1   (reqAddress_P1),
    .reqDataIn_P0    (reqDataIn_P0),
    .reqDataIn_P1    (reqDataIn_P1),
    .reqWen_P0       (reqWen_P0),
    .reqWen_P1       (reqWen_P1),
    .respDataOut_P0  (respDataOut_P0),
    .respDataOut_P1  (respDataOut_P1),
    .respHit_P0      (respHit_P0),
    .respHit_P1      (respHit_P1),
    .reqValid_CPU    (reqValid_CPU),
    .reqAddress_CPU  (reqAddress_CPU),
    .reqDataIn_CPU   (reqDataIn_CPU),
    .reqWen_CPU      (reqWen_CPU),
    .respDataOut_CPU (respDataOut_CPU),
    .respHit_CPU     (respHit_CPU),
    .grant           (grant),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wen;
  } req_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Scoreboard: downstream requests and requester completions, checked on the falling edge.
  logic mon_v = 1'b0, mon_h0 = 1'b0, mon_h1 = 1'b0;
  always @(negedge clk) begin
    req_t er, orq;
    rsp_t es, os;
    if (rst) begin
      mon_v = 1'b0; mon_h0 = 1'b0; mon_h1 = 1'b0;
    end else begin
      if (reqValid_CPU && !mon_v) begin
        vectors++;
        orq = {grant, reqAddress_CPU, reqDataIn_CPU, reqWen_CPU};
        if (exp_req_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_req: unexpected request %h, none expected", orq);
        end else begin
          er = exp_req_q.pop_front();
          if (orq !== er) begin
            miscompares++;
            $display("FAIL sb_req: got %h expected %h", orq, er);
          end
        end
      end
      if ((respHit_P0 && !mon_h0) || (respHit_P1 && !mon_h1)) begin
        vectors++;
        os = respHit_P1 ? {1'b1, respDataOut_P1} : {1'b0, respDataOut_P0};
        if (exp_rsp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_rsp: unexpected response %h, none expected", os);
        end else begin
          es = exp_rsp_q.pop_front();
          if (os !== es) begin
            miscompares++;
            $display("FAIL sb_rsp: got %h expected %h", os, es);
          end
        end
      end
      if ((!respHit_P0 && respDataOut_P0 !== '0) || (!respHit_P1 && respDataOut_P1 !== '0) ||
          (respHit_P0 && respHit_P1) || (reqValid_CPU && (respHit_P0 || respHit_P1))) begin
        miscompares++;
        $display("FAIL invariant: hit=%b%b d0=%h d1=%h vcpu=%b", respHit_P1, respHit_P0,
                 respDataOut_P0, respDataOut_P1, reqValid_CPU);
      end
      mon_v  = reqValid_CPU;
      mon_h0 = respHit_P0;
      mon_h1 = respHit_P1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reqValid_P0 = 0; reqValid_P1 = 0;
    reqAddress_P0 = '0; reqAddress_P1 = '0;
    reqDataIn_P0 = '0; reqDataIn_P1 = '0;
    reqWen_P0 = 0; reqWen_P1 = 0;
    respHit_CPU = 0; respDataOut_CPU = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick(2);
    rst = 1'b0;
  endtask

  // Bounded wait for the next downstream request.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!reqValid_CPU && n < 50) begin
      tick(1);
      n++;
    end
    if (!reqValid_CPU) begin
      miscompares++;
      $display("FAIL %s_wait: reqValid_CPU never rose within 50 cycles", tag);
    end
  endtask

  task automatic respond(input logic [DW-1:0] d);
    respHit_CPU = 1'b1;
    respDataOut_CPU = d;
    tick(1);
    respHit_CPU = 1'b0;
    respDataOut_CPU = $urandom;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({reqValid_CPU, reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, respHit_P0, respHit_P1,
         respDataOut_P0, respDataOut_P1, grant, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: vcpu=%b a=%h d=%h w=%b hit=%b%b g=%b to=%b, required all 0",
               reqValid_CPU, reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, respHit_P1, respHit_P0,
               grant, timeout_err);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    reqValid_P0 = 1; reqAddress_P0 = 32'h0000_0000; reqDataIn_P0 = 32'h0023_42AB; reqWen_P0 = 1;
    exp_req_q.push_back({2'b01, 32'h0000_0000, 32'h0023_42AB, 1'b1});
    exp_rsp_q.push_back({1'b0, 32'h0BAD_F00D});
    vectors++;
    if (reqValid_CPU !== 1'b0) begin
      miscompares++; $display("FAIL sw_latency: reqValid_CPU=%b same cycle, required 0", reqValid_CPU);
    end
    tick(1);
    vectors++;
    if (reqValid_CPU !== 1'b1 || grant !== 2'b01) begin
      miscompares++; $display("FAIL sw_issue: vcpu=%b grant=%b, required 1/01", reqValid_CPU, grant);
    end
    tick(2);
    respond(32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (respHit_P0 !== 1'b1 || respDataOut_P0 !== 32'h0BAD_F00D || respHit_P1 !== 1'b0 || grant !== 2'b01) begin
        miscompares++;
        $display("FAIL sw_hold%0d: hit0=%b d0=%h hit1=%b g=%b, required 1/0badf00d/0/01",
                 i, respHit_P0, respDataOut_P0, respHit_P1, grant);
      end
      tick(1);
    end
    reqValid_P0 = 0;
    tick(1);
    vectors++;
    if (respHit_P0 !== 1'b0 || grant !== 2'b00) begin
      miscompares++; $display("FAIL sw_release: hit0=%b grant=%b, required 0/00", respHit_P0, grant);
    end
  endtask

  task automatic test_tie();
    int gap;
    do_reset();
    reqValid_P0 = 1; reqAddress_P0 = 32'h10; reqDataIn_P0 = 32'h1111; reqWen_P0 = 0;
    reqValid_P1 = 1; reqAddress_P1 = 32'h20; reqDataIn_P1 = 32'h2222; reqWen_P1 = 0;
    exp_req_q.push_back({2'b01, 32'h10, 32'h1111, 1'b0});
    exp_req_q.push_back({2'b10, 32'h20, 32'h2222, 1'b0});
    exp_rsp_q.push_back({1'b0, 32'hA0A0});
    exp_rsp_q.push_back({1'b1, 32'hB0B0});
    wait_valid("tie0");
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++; $display("FAIL tie_first: grant=%b, required 01", grant);
    end
    respond(32'hA0A0);
    reqValid_P0 = 0;
    gap = 0;
    while (!reqValid_CPU && gap < 20) begin
      tick(1);
      gap++;
    end
    vectors++;
    if (gap < 1 || grant !== 2'b10) begin
      miscompares++; $display("FAIL tie_second: gap=%0d grant=%b, required >=1 and 10", gap, grant);
    end
    respond(32'hB0B0);
    reqValid_P1 = 0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    do_reset();
    reqValid_P0 = 1; reqAddress_P0 = 32'h100; reqDataIn_P0 = 32'hD0; reqWen_P0 = 1;
    reqValid_P1 = 1; reqAddress_P1 = 32'h200; reqDataIn_P1 = 32'hD1; reqWen_P1 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        exp_req_q.push_back({2'b01, 32'h100, 32'hD0, 1'b1});
        exp_rsp_q.push_back({1'b0, 32'hC000 + 32'(i)});
      end else begin
        exp_req_q.push_back({2'b10, 32'h200, 32'hD1, 1'b0});
        exp_rsp_q.push_back({1'b1, 32'hC000 + 32'(i)});
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_valid("b2b");
      vectors++;
      if (grant !== exp_g) begin
        miscompares++; $display("FAIL b2b_order%0d: grant=%b, required %b", i, grant, exp_g);
      end
      respond(32'hC000 + 32'(i));
      if (i == 3) begin
        reqValid_P0 = 0; reqValid_P1 = 0;
        tick(3);
      end else begin
        if (exp_g[0]) reqValid_P0 = 0; else reqValid_P1 = 0;
        tick(1);
        if (exp_g[0]) reqValid_P0 = 1; else reqValid_P1 = 1;
      end
    end
  endtask

  task automatic test_addr_hold();
    do_reset();
    reqValid_P1 = 1; reqAddress_P1 = 32'h24; reqDataIn_P1 = 32'h55; reqWen_P1 = 0;
    exp_req_q.push_back({2'b10, 32'h24, 32'h55, 1'b0});
    exp_rsp_q.push_back({1'b1, 32'h7777});
    tick(1);
    reqAddress_P1 = 32'h30; reqDataIn_P1 = 32'h66; reqWen_P1 = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vectors++;
      if (reqValid_CPU !== 1'b1 || reqAddress_CPU !== 32'h24 || reqDataIn_CPU !== 32'h55 || reqWen_CPU !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: v=%b a=%h d=%h w=%b, required 1/24/55/0",
                 i, reqValid_CPU, reqAddress_CPU, reqDataIn_CPU, reqWen_CPU);
      end
    end
    respond(32'h7777);
    vectors++;
    if (respHit_P1 !== 1'b1 || respDataOut_P1 !== 32'h7777 || respHit_P0 !== 1'b0 || respDataOut_P0 !== '0) begin
      miscompares++;
      $display("FAIL hold_resp: hit1=%b d1=%h hit0=%b d0=%h, required 1/7777/0/0",
               respHit_P1, respDataOut_P1, respHit_P0, respDataOut_P0);
    end
    reqValid_P1 = 0;
    tick(2);
  endtask

  task automatic test_drop_early();
    do_reset();
    reqValid_P0 = 1; reqAddress_P0 = 32'h40; reqDataIn_P0 = 32'h9; reqWen_P0 = 0;
    exp_req_q.push_back({2'b01, 32'h40, 32'h9, 1'b0});
    exp_rsp_q.push_back({1'b0, 32'h1234});
    tick(1);
    reqValid_P0 = 0;
    tick(2);
    vectors++;
    if (reqValid_CPU !== 1'b1) begin
      miscompares++; $display("FAIL drop_keep: reqValid_CPU=%b, required 1", reqValid_CPU);
    end
    respond(32'h1234);
    vectors++;
    if (respHit_P0 !== 1'b1) begin
      miscompares++; $display("FAIL drop_gap: hit0=%b, required 1", respHit_P0);
    end
    tick(1);
    vectors++;
    if (respHit_P0 !== 1'b0 || grant !== 2'b00) begin
      miscompares++; $display("FAIL drop_exit: hit0=%b grant=%b, required 0/00", respHit_P0, grant);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    reqValid_P0 = 1; reqAddress_P0 = 32'h80; reqDataIn_P0 = 32'h8; reqWen_P0 = 0;
`ifdef CACHE_ARB_TIMEOUT_EN
    exp_req_q.push_back({2'b01, 32'h80, 32'h8, 1'b0});
    exp_rsp_q.push_back({1'b0, 32'h0});
    tick(TO);
    vectors++;
    if (reqValid_CPU !== 1'b1 || timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL to_last_issue: v=%b to=%b, required 1/0", reqValid_CPU, timeout_err);
    end
    tick(1);
    vectors++;
    if (timeout_err !== 1'b1 || respHit_P0 !== 1'b1 || respDataOut_P0 !== '0 || reqValid_CPU !== 1'b0) begin
      miscompares++;
      $display("FAIL to_fire: to=%b hit0=%b d0=%h v=%b, required 1/1/0/0",
               timeout_err, respHit_P0, respDataOut_P0, reqValid_CPU);
    end
    tick(1);
    vectors++;
    if (timeout_err !== 1'b0 || respHit_P0 !== 1'b1) begin
      miscompares++; $display("FAIL to_pulse: to=%b hit0=%b, required 0/1", timeout_err, respHit_P0);
    end
    reqValid_P0 = 0;
    tick(1);
    reqValid_P0 = 1;
    exp_req_q.push_back({2'b01, 32'h80, 32'h8, 1'b0});
    exp_rsp_q.push_back({1'b0, 32'hFEED});
    tick(TO);
    respond(32'hFEED);
    vectors++;
    if (timeout_err !== 1'b0 || respHit_P0 !== 1'b1 || respDataOut_P0 !== 32'hFEED) begin
      miscompares++;
      $display("FAIL to_race: to=%b hit0=%b d0=%h, required 0/1/feed", timeout_err, respHit_P0, respDataOut_P0);
    end
`else
    exp_req_q.push_back({2'b01, 32'h80, 32'h8, 1'b0});
    exp_rsp_q.push_back({1'b0, 32'h5A5A});
    tick(1);
    for (int i = 0; i < 3 * TO; i++) begin
      vectors++;
      if (reqValid_CPU !== 1'b1 || timeout_err !== 1'b0) begin
        miscompares++;
        $display("FAIL nowd_%0d: v=%b to=%b, required 1/0", i, reqValid_CPU, timeout_err);
      end
      tick(1);
    end
    respond(32'h5A5A);
`endif
    reqValid_P0 = 0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    do_reset();
    reqValid_P0 = 1; reqAddress_P0 = 32'hCAFE; reqDataIn_P0 = 32'hBEEF; reqWen_P0 = 1;
    exp_req_q.push_back({2'b01, 32'hCAFE, 32'hBEEF, 1'b1});
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    reqValid_P0 = 0;
    vectors++;
    if ({reqValid_CPU, reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, respHit_P0, respHit_P1,
         respDataOut_P0, respDataOut_P1, grant, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outs: v=%b a=%h d=%h w=%b hit=%b%b g=%b, required all 0",
               reqValid_CPU, reqAddress_CPU, reqDataIn_CPU, reqWen_CPU, respHit_P1, respHit_P0, grant);
    end
    respHit_CPU = 1'b1;
    respDataOut_CPU = 32'h1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vectors++;
      if (respHit_P0 !== 1'b0 || reqValid_CPU !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_quiet%0d: hit0=%b v=%b, required 0/0", i, respHit_P0, reqValid_CPU);
      end
    end
    respHit_CPU = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_tie();
    test_back_to_back();
    test_addr_hold();
    test_drop_early();
    test_timeout();
    test_reset_mid();
    tick(2);
    vectors++;
    if (exp_req_q.size() != 0 || exp_rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d requests and %0d responses left, required 0/0",
               exp_req_q.size(), exp_rsp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at 200000, required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
